// File: rtl/skew_feeder_pkg.sv
// Shared types and sizing helpers for the skew feeder and the triangle arrays
// it drives.
package skew_feeder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FLUSH,
        DONE
    } state_e;

    localparam int LANE_WIDTH = 16;

    // Never returns zero, so a one-deep counter still has a legal width.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/skew_feeder_if.sv
// Operand-buffer handshake plus triangle-array drive and controller status
// for one skew feeder.
interface skew_feeder_if
    import skew_feeder_pkg::*;
#(
    parameter int HIGHT      = 8,
    parameter int DATA_WIDTH = LANE_WIDTH
);
    logic                         in_valid;
    logic                         in_ready;
    logic [HIGHT*DATA_WIDTH-1:0]  in_data;
    logic                         in_last;
    logic                         out_enable;
    logic [HIGHT*DATA_WIDTH-1:0]  out_data;
    logic                         busy;
    logic                         done;
    logic                         overrun;

    modport master (
        output in_valid, in_data, in_last,
        input  in_ready, out_enable, out_data, busy, done, overrun
    );

    modport slave (
        input  in_valid, in_data, in_last,
        output in_ready, out_enable, out_data, busy, done, overrun
    );
endinterface

// File: rtl/skew_feeder_flush.sv
// Load/decrement down-counter that times the zero-vector drain of the
// skewed wavefront.
module flush_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt_d, cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
endmodule

// File: rtl/skew_feeder.sv
// Streams one tile of row vectors into the triangle skew array, then appends
// HIGHT-1 zero vectors so every lane of the wavefront drains.
//
// state  | meaning
// IDLE   | waiting for the first vector of a tile
// STREAM | tile in progress, forwarding vectors, bubbles freeze the array
// FLUSH  | driving HIGHT-1 zero vectors with enable held high
// DONE   | drain finished, done pulses in the following cycle
module skew_feeder
    import skew_feeder_pkg::*;
#(
    parameter int HIGHT       = 8,
    parameter int DATA_WIDTH  = LANE_WIDTH,
    parameter int MAX_VECTORS = 64
) (
    input  logic               clk,
    input  logic               rst,
    skew_feeder_if.slave       bus
);
    localparam int VW = cnt_width(MAX_VECTORS + 1);
    localparam int FW = cnt_width(HIGHT);
    localparam int DW = HIGHT * DATA_WIDTH;
    localparam logic [VW-1:0] LAST_IDX   = VW'(MAX_VECTORS - 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'((HIGHT >= 2) ? HIGHT - 2 : 0);

    state_e        state_d, state_q;
    logic [VW-1:0] vec_cnt_d, vec_cnt_q;
    logic [DW-1:0] out_data_d, out_data_q;
    logic          out_en_d, out_en_q;
    logic          busy_d, busy_q;
    logic          done_d, done_q;
    logic          overrun_d, overrun_q;
    logic          in_ready;
    logic          accept;
    logic          hit_max;
    logic          fc_load, fc_dec, fc_zero;

    assign in_ready = (state_q == IDLE) || (state_q == STREAM);
    assign accept   = bus.in_valid && in_ready;
    assign hit_max  = !bus.in_last && (vec_cnt_q == LAST_IDX);

    always_comb begin
        state_d    = state_q;
        out_en_d   = 1'b0;
        out_data_d = out_data_q;
        overrun_d  = overrun_q;
        fc_load    = 1'b0;
        fc_dec     = 1'b0;
        case (state_q)
            IDLE, STREAM: begin
                if (accept) begin
                    out_en_d   = 1'b1;
                    out_data_d = bus.in_data;
                    if (state_q == IDLE) begin
                        overrun_d = 1'b0;
                    end
                    if (hit_max) begin
                        overrun_d = 1'b1;
                    end
                    if (bus.in_last || hit_max) begin
                        state_d = (HIGHT == 1) ? DONE : FLUSH;
                        fc_load = 1'b1;
                    end else begin
                        state_d = STREAM;
                    end
                end
            end
            FLUSH: begin
                out_en_d   = 1'b1;
                out_data_d = '0;
                if (fc_zero) begin
                    state_d = DONE;
                end else begin
                    fc_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        vec_cnt_d = vec_cnt_q;
        if (state_d == IDLE) begin
            vec_cnt_d = '0;
        end else if (accept) begin
            vec_cnt_d = vec_cnt_q + VW'(1);
        end
    end

    // busy covers the done cycle, so it is taken from the current state.
    assign busy_d = (state_q != IDLE) || accept;
    assign done_d = (state_q == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_cnt_q  <= '0;
            out_data_q <= '0;
            out_en_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_cnt_q  <= vec_cnt_d;
            out_data_q <= out_data_d;
            out_en_q   <= out_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    flush_counter #(.W(FW)) u_flush (
        .clk      (clk),
        .rst      (rst),
        .load     (fc_load),
        .dec      (fc_dec),
        .load_val (FLUSH_LOAD),
        .zero     (fc_zero)
    );

    assign bus.in_ready   = in_ready;
    assign bus.out_enable = out_en_q;
    assign bus.out_data   = out_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_skew_feeder.sv
// Scoreboard bench for skew_feeder: driver pushes expected vectors and done
// cycles, a negedge monitor pops and compares.
module tb_skew_feeder;
    import skew_feeder_pkg::*;

    localparam int H  = 8;
    localparam int DW = 16;
    localparam int MV = 4;
    localparam int VB = H * DW;

    logic clk = 1'b0;
    logic rst = 1'b1;

    skew_feeder_if #(.HIGHT(H), .DATA_WIDTH(DW)) bus ();

    skew_feeder #(.HIGHT(H), .DATA_WIDTH(DW), .MAX_VECTORS(MV)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    logic [VB-1:0] exp_q[$];
    int            exp_done[$];
    logic [VB-1:0] last_exp = '0;
    int bubble_cnt = 0;
    int done_cnt   = 0;
    int tile_cnt   = 0;
    int acc_cyc    = 0;
    int stall_cyc  = 0;

    function automatic logic [VB-1:0] splat(input logic [DW-1:0] v);
        logic [VB-1:0] r;
        r = '0;
        for (int i = 0; i < H; i++) r[lane_lsb(i, DW) +: DW] = v;
        return r;
    endfunction

    task automatic check(input string name, input logic [VB-1:0] act, input logic [VB-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.out_enable) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL out_unexpected: got enable with data %0h expected no output (cycle %0d)",
                             bus.out_data, cyc);
                end else begin
                    last_exp = exp_q.pop_front();
                    check("out_data", bus.out_data, last_exp);
                end
            end else if (bus.busy && !bus.done) begin
                bubble_cnt++;
                check("bubble_hold", bus.out_data, last_exp);
            end
            if (bus.done) begin
                done_cnt++;
                if (exp_done.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL done_unexpected: got done at cycle %0d expected none", cyc);
                end else begin
                    check("done_cycle", VB'(cyc), VB'(exp_done.pop_front()));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds the vector on the bus until accepted; in_valid stays high afterwards.
    task automatic send(input logic [VB-1:0] d, input logic last);
        bit ok;
        ok = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        stall_cyc    = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            #3;
            if (bus.in_ready) begin
                ok = 1'b1;
                acc_cyc = cyc;
                exp_q.push_back(d);
                tile_cnt++;
                if (last || tile_cnt == MV) begin
                    for (int k = 0; k < H - 1; k++) exp_q.push_back('0);
                    exp_done.push_back(cyc + H + 1);
                    tile_cnt = 0;
                end
            end else begin
                stall_cyc++;
            end
            tick();
        end
        if (!ok) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got no accept expected accept within 40 cycles");
        end
    endtask

    // Called in the cycle after a tile's final accept; returns mid done cycle.
    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            #3;
            if (bus.done) begin
                seen = 1'b1;
                check("busy_at_done", VB'(bus.busy), VB'(1));
                check("ready_at_done", VB'(bus.in_ready), VB'(1));
            end else begin
                check("ready_low_flush", VB'(bus.in_ready), VB'(0));
                tick();
            end
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected done within 40 cycles");
        end
    endtask

    initial begin
        int t0;
        int b0;
        int d0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (3) tick();
        check("rst_in_ready",   VB'(bus.in_ready),   VB'(1));
        check("rst_out_enable", VB'(bus.out_enable), VB'(0));
        check("rst_out_data",   bus.out_data,        '0);
        check("rst_busy",       VB'(bus.busy),       VB'(0));
        check("rst_done",       VB'(bus.done),       VB'(0));
        check("rst_overrun",    VB'(bus.overrun),    VB'(0));
        rst = 1'b0;
        tick();

        // Basic 3-vector tile, valid held high.
        send(splat(16'h0001), 1'b0);
        t0 = acc_cyc;
        send(splat(16'h0002), 1'b0);
        send(splat(16'h0003), 1'b1);
        bus.in_valid = 1'b0;
        check("basic_last_acc", VB'(acc_cyc), VB'(t0 + 2));
        wait_done();
        tick();

        // Single vector tile.
        send(splat(16'hA5A5), 1'b1);
        bus.in_valid = 1'b0;
        wait_done();
        tick();
        #3;
        check("single_busy_drop", VB'(bus.busy), VB'(0));
        tick();

        // Four vectors with two bubbles after the first.
        b0 = bubble_cnt;
        send(splat(16'h0011), 1'b0);
        t0 = acc_cyc;
        bus.in_valid = 1'b0;
        tick();
        tick();
        send(splat(16'h0022), 1'b0);
        send(splat(16'h0033), 1'b0);
        send(splat(16'h0044), 1'b1);
        bus.in_valid = 1'b0;
        check("bubble_last_acc", VB'(acc_cyc), VB'(t0 + 5));
        wait_done();
        check("bubble_count", VB'(bubble_cnt - b0), VB'(2));
        tick();

        // Overrun: four accepts without in_last, more vectors kept on offer.
        send(splat(16'h0101), 1'b0);
        send(splat(16'h0202), 1'b0);
        send(splat(16'h0303), 1'b0);
        send(splat(16'h0404), 1'b0);
        t0 = acc_cyc;
        bus.in_data = splat(16'h0505);
        wait_done();
        check("overrun_set", VB'(bus.overrun), VB'(1));
        send(splat(16'h0505), 1'b0);
        check("overrun_next_acc", VB'(acc_cyc), VB'(t0 + H + 1));
        #3;
        check("overrun_clear", VB'(bus.overrun), VB'(0));
        send(splat(16'h0606), 1'b1);
        bus.in_valid = 1'b0;
        wait_done();
        tick();

        // Reset during the third flush cycle.
        send(splat(16'h0077), 1'b0);
        send(splat(16'h0088), 1'b1);
        bus.in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        exp_done.delete();
        tile_cnt = 0;
        d0 = done_cnt;
        #3;
        check("rmid_in_ready",   VB'(bus.in_ready),   VB'(1));
        check("rmid_out_enable", VB'(bus.out_enable), VB'(0));
        check("rmid_busy",       VB'(bus.busy),       VB'(0));
        check("rmid_done",       VB'(bus.done),       VB'(0));
        repeat (12) tick();
        check("rmid_no_done", VB'(done_cnt - d0), VB'(0));

        // Back-to-back tiles with valid held continuously.
        send(splat(16'h00B1), 1'b0);
        send(splat(16'h00B2), 1'b1);
        t0 = acc_cyc;
        send(splat(16'h00C1), 1'b0);
        check("b2b_stall", VB'(stall_cyc), VB'(H));
        check("b2b_next_acc", VB'(acc_cyc), VB'(t0 + H + 1));
        send(splat(16'h00C2), 1'b1);
        bus.in_valid = 1'b0;
        wait_done();
        tick();
        tick();

        check("drain_out_queue",  VB'(exp_q.size()),    VB'(0));
        check("drain_done_queue", VB'(exp_done.size()), VB'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
